// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and header size for the ALU packet engine
package alu_pkg;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hA0
  } opcode_e;

  typedef enum logic [2:0] {
    S_OPC,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_ADD,
    S_SEND,
    S_DRAIN
  } state_e;

  localparam logic [15:0] HDR_BYTES = 16'd4;

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - 1-entry AXI-stream register stage
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_tdata,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [W-1:0] out_tdata,
  output logic         out_tvalid,
  input  logic         out_tready
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  assign in_tready  = !valid_q || out_tready;
  assign out_tdata  = data_q;
  assign out_tvalid = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_tready) begin
      valid_d = in_tvalid;
      if (in_tvalid) data_d = in_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/alu_packet_engine.sv
// rtl/alu_packet_engine.sv - UART ALU link responder: parses ECHO/ADD packets, streams replies
module alu_packet_engine
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH_P = 8,
  parameter int ACC_WIDTH_P  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
  input  logic                    rx_tvalid_i,
  output logic                    rx_tready_o,
  output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
  output logic                    tx_tvalid_o,
  input  logic                    tx_tready_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int         NB     = ACC_WIDTH_P / 8;
  localparam logic [7:0] NB_B   = 8'(NB);
  localparam logic [7:0] LAST_K = 8'(NB - 1);

  state_e                  state_q, state_d;
  logic [7:0]              opc_q, opc_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [15:0]             rem_q, rem_d;
  logic [ACC_WIDTH_P-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH_P-1:0]  word_q, word_d;
  logic [7:0]              k_q, k_d;
  logic [7:0]              send_cnt_q, send_cnt_d;
  logic                    err_q, err_d;

  logic                    ready_int;
  logic                    rx_fire, tx_fire;
  logic                    skid_in_valid, skid_in_ready;
  logic [DATA_WIDTH_P-1:0] skid_in_data;
  logic [15:0]             len_w;
  logic [ACC_WIDTH_P-1:0]  word_next;

  axis_skid_reg #(.W(DATA_WIDTH_P)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_tdata   (skid_in_data),
    .in_tvalid  (skid_in_valid),
    .in_tready  (skid_in_ready),
    .out_tdata  (tx_tdata_o),
    .out_tvalid (tx_tvalid_o),
    .out_tready (tx_tready_i)
  );

  always_comb begin
    ready_int = 1'b1;
    case (state_q)
      S_ECHO:  ready_int = skid_in_ready;
      S_SEND:  ready_int = 1'b0;
      default: ready_int = 1'b1;
    endcase
  end

  assign rx_tready_o = !rst && ready_int;
  assign rx_fire     = rx_tvalid_i && rx_tready_o;
  assign tx_fire     = tx_tvalid_o && tx_tready_i;
  assign busy_o      = (state_q != S_OPC);
  assign err_o       = err_q;

  // The skid register is shared: ECHO forwards rx bytes, SEND feeds accumulator bytes LSB first.
  always_comb begin
    skid_in_valid = 1'b0;
    skid_in_data  = rx_tdata_i;
    if (state_q == S_ECHO) begin
      skid_in_valid = rx_tvalid_i;
    end else if (state_q == S_SEND) begin
      skid_in_valid = (send_cnt_q != NB_B);
      skid_in_data  = DATA_WIDTH_P'(acc_q >> {send_cnt_q, 3'b000});
    end
  end

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    len_lo_d   = len_lo_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    word_d     = word_q;
    k_d        = k_q;
    send_cnt_d = send_cnt_q;
    err_d      = 1'b0;
    len_w      = {rx_tdata_i, len_lo_q};
    word_next  = word_q | (ACC_WIDTH_P'(rx_tdata_i) << {k_q, 3'b000});

    case (state_q)
      S_OPC: if (rx_fire) begin
        opc_d   = rx_tdata_i;
        state_d = S_RSVD;
      end
      S_RSVD: if (rx_fire) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_fire) begin
        len_lo_d = rx_tdata_i;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (rx_fire) begin
        acc_d      = '0;
        word_d     = '0;
        k_d        = '0;
        send_cnt_d = '0;
        rem_d      = len_w - HDR_BYTES;
        if (len_w < HDR_BYTES) begin
          err_d   = 1'b1;
          state_d = S_OPC;
        end else if (len_w == HDR_BYTES) begin
          if (opc_q == OP_ADD) begin
            state_d = S_SEND;
          end else begin
            err_d   = (opc_q != OP_ECHO);
            state_d = S_OPC;
          end
        end else if (opc_q == OP_ECHO) begin
          state_d = S_ECHO;
        end else if (opc_q == OP_ADD) begin
          state_d = S_ADD;
        end else begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_ECHO, S_DRAIN: if (rx_fire) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = S_OPC;
      end
      S_ADD: if (rx_fire) begin
        rem_d = rem_q - 16'd1;
        // A short final word is committed zero-extended on the packet's last byte.
        if (k_q == LAST_K || rem_q == 16'd1) begin
          acc_d  = acc_q + word_next;
          word_d = '0;
          k_d    = '0;
        end else begin
          word_d = word_next;
          k_d    = k_q + 8'd1;
        end
        if (rem_q == 16'd1) state_d = S_SEND;
      end
      S_SEND: begin
        if (skid_in_valid && skid_in_ready) send_cnt_d = send_cnt_q + 8'd1;
        if (send_cnt_q == NB_B && tx_fire) begin
          acc_d   = '0;
          state_d = S_OPC;
        end
      end
      default: state_d = S_OPC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OPC;
      opc_q      <= '0;
      len_lo_q   <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      word_q     <= '0;
      k_q        <= '0;
      send_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      word_q     <= word_d;
      k_q        <= k_d;
      send_cnt_q <= send_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule
